// File: rtl/mux_4_rr_arbiter_pkg.sv
// mux_4_rr_pkg: shared sizes, index type and rotating-priority pick function
package mux_4_rr_pkg;
    localparam int N_REQ = 4, DATA_W = 4;
    typedef logic [1:0] idx_t;
    typedef struct packed {
        logic found;
        idx_t idx;
    } pick_t;
    // Scan from the farthest offset down so the nearest requester after ptr wins
    function automatic pick_t rr_pick(input logic [N_REQ-1:0] req, input idx_t ptr);
        pick_t p;
        idx_t i;
        p = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            i = ptr + idx_t'(k);
            if (req[i]) begin
                p.found = 1'b1;
                p.idx = i;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/mux_4_rr_arbiter_if.sv
// mux_4_rr_arbiter_if: requester/consumer bundle around the arbiter
interface mux_4_rr_arbiter_if;
    import mux_4_rr_pkg::*;
    logic [N_REQ-1:0] req, gnt;
    logic [DATA_W-1:0] d0, d1, d2, d3, y;
    logic y_valid, y_ready;
    idx_t sel;
    modport slave(input req, d0, d1, d2, d3, y_ready, output gnt, y, y_valid, sel);
    modport master(output req, d0, d1, d2, d3, y_ready, input gnt, y, y_valid, sel);
endinterface

// File: rtl/mux_4_1.sv
// mux_4_1: 4-bit four-way data select
module mux_4_1 (
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    assign y = sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0);
endmodule

// File: rtl/mux_4_rr_arbiter_rr_pick4.sv
// rr_pick4: combinational rotating priority encoder over four requests
module rr_pick4
    import mux_4_rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  idx_t             ptr,
    output logic             found,
    output idx_t             idx
);
    pick_t p;
    assign p = rr_pick(req, ptr);
    assign found = p.found;
    assign idx = p.idx;
endmodule

// File: rtl/mux_4_rr_arbiter.sv
// mux_4_rr_arbiter: round-robin share of one registered 4-bit channel among four requesters
module mux_4_rr_arbiter
    import mux_4_rr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    mux_4_rr_arbiter_if.slave    bus
);
    idx_t ptr, idx;
    logic found, accept, xfer;
    logic [DATA_W-1:0] mux_y;
    rr_pick4 u_pick (.req(bus.req), .ptr(ptr), .found(found), .idx(idx));
    mux_4_1 u_mux (.d0(bus.d0), .d1(bus.d1), .d2(bus.d2), .d3(bus.d3), .sel(idx), .y(mux_y));
    assign accept = !bus.y_valid || bus.y_ready;
    assign xfer = accept && found && rst_n;
    assign bus.gnt = xfer ? (4'b0001 << idx) : 4'b0000;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.y <= '0;
            bus.sel <= '0;
            bus.y_valid <= 1'b0;
            ptr <= '0;
        end else if (accept) begin
            bus.y_valid <= found;
            if (found) begin
                bus.y <= mux_y;
                bus.sel <= idx;
                ptr <= idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux_4_rr_arbiter.sv
// tb_mux_4_rr_arbiter: directed vector table plus hand sequences for drain and mid-stream reset
module tb_mux_4_rr_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    int passed = 0, total = 0;
    mux_4_rr_arbiter_if bus();
    mux_4_rr_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [3:0] y;
        logic       v;
        logic [1:0] sel;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] q, input logic k, input logic [3:0] g,
                       input logic [3:0] yy, input logic v, input logic [1:0] s);
        vec_t e;
        e.rst_n = r; e.req = q; e.rdy = k; e.gnt = g; e.y = yy; e.v = v; e.sel = s;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle: gnt checked before the edge, registered outputs just after it
    task automatic step(input string name, input logic r, input logic [3:0] q, input logic k,
                        input logic [3:0] g, input logic [3:0] yy, input logic v, input logic [1:0] s);
        rst_n = r; bus.req = q; bus.y_ready = k;
        #1;
        chk({name, " gnt"}, bus.gnt, g);
        @(posedge clk);
        #1;
        chk({name, " y"}, bus.y, yy);
        chk({name, " y_valid"}, {3'b0, bus.y_valid}, {3'b0, v});
        chk({name, " sel"}, {2'b0, bus.sel}, {2'b0, s});
    endtask

    initial begin
        bus.req = 4'h0; bus.y_ready = 1'b0;
        bus.d0 = 4'hA; bus.d1 = 4'hB; bus.d2 = 4'hC; bus.d3 = 4'hD;
        add(0, 4'hF, 1, 4'b0000, 4'h0, 0, 0);
        add(0, 4'hF, 1, 4'b0000, 4'h0, 0, 0);
        add(1, 4'hF, 1, 4'b0001, 4'hA, 1, 0);
        add(1, 4'hF, 1, 4'b0010, 4'hB, 1, 1);
        add(1, 4'hF, 1, 4'b0100, 4'hC, 1, 2);
        add(1, 4'hF, 1, 4'b1000, 4'hD, 1, 3);
        add(1, 4'hF, 1, 4'b0001, 4'hA, 1, 0);
        add(1, 4'hF, 1, 4'b0010, 4'hB, 1, 1);
        add(1, 4'hF, 1, 4'b0100, 4'hC, 1, 2);
        add(1, 4'hF, 1, 4'b1000, 4'hD, 1, 3);
        add(1, 4'b1000, 1, 4'b1000, 4'hD, 1, 3);
        add(1, 4'b1010, 1, 4'b0010, 4'hB, 1, 1);
        add(1, 4'b1010, 1, 4'b1000, 4'hD, 1, 3);
        add(1, 4'b0001, 1, 4'b0001, 4'hA, 1, 0);
        add(1, 4'b0110, 0, 4'b0000, 4'hA, 1, 0);
        add(1, 4'b0110, 0, 4'b0000, 4'hA, 1, 0);
        add(1, 4'b0110, 0, 4'b0000, 4'hA, 1, 0);
        add(1, 4'b0110, 1, 4'b0010, 4'hB, 1, 1);
        add(1, 4'b0000, 1, 4'b0000, 4'hB, 0, 1);
        add(1, 4'b0000, 0, 4'b0000, 4'hB, 0, 1);
        add(1, 4'b0100, 0, 4'b0100, 4'hC, 1, 2);
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].rdy,
                 tbl[i].gnt, tbl[i].y, tbl[i].v, tbl[i].sel);
        bus.d2 = 4'h7;
        step("drain_load", 1, 4'b0100, 1, 4'b0100, 4'h7, 1, 2);
        step("drain_empty", 1, 4'b0000, 1, 4'b0000, 4'h7, 0, 2);
        step("drain_idle", 1, 4'b0000, 1, 4'b0000, 4'h7, 0, 2);
        step("mid_load", 1, 4'b0010, 1, 4'b0010, 4'hB, 1, 1);
        step("mid_reset", 0, 4'b1111, 1, 4'b0000, 4'h0, 0, 0);
        step("post_reset", 1, 4'b1111, 1, 4'b0001, 4'hA, 1, 0);
        step("post_next", 1, 4'b1111, 1, 4'b0010, 4'hB, 1, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
